rx_mac2router: RTL

Receive-side adapter between the 10G MAC receive interface and the router input port, the counterpart of the transmit-side router-to-MAC adapter. It takes 64-bit MAC beats with a 4-bit byte-valid code and an end-of-frame flag. It packs each beat into a 70-bit router flit with begin- and end-of-packet markers and buffers the flits in a small FIFO, because the MAC cannot be back-pressured. Flits are delivered to the router under a val/ack handshake. On overflow, the rest of the frame is dropped, and any partial frame already buffered is closed with a terminator flit.

---
 rtl/rx_mac2router.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rx_mac2router.sv
// rx_mac2router
// Receive-side adapter from the 10G MAC receive interface to a router input
// port. Each MAC beat becomes one 70-bit flit {bop, eop, data[63:0], valid[3:0]}
// and is held in a small first-word-fall-through FIFO, because the MAC cannot
// be stalled. Flits leave under a val/ack handshake. When the FIFO runs out of
// room, the rest of the frame is dropped. A partial frame that is already
// buffered is closed with a terminator flit {0, 1, 64'h0, 4'h0}.
//
// Optional build macro: RX_MAC2ROUTER_STATS_EN enables the frame_cnt/drop_cnt
// statistics counters. When the macro is undefined, both outputs are tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   data_mac     64-bit MAC receive beat
//   valid_mac    byte-valid code, 0 = idle cycle
//   eof_mac      last beat of frame (qualified by valid_mac != 0)
//   data_router  head flit, 0 when the FIFO is empty
//   val          head flit present
//   ack          router consumes the head flit
//   overflow     one-cycle pulse after the first dropped beat of a frame
//   frame_cnt    frames fully accepted (saturating, stats build)
//   drop_cnt     frames truncated or discarded (saturating, stats build)
module rx_mac2router #(
  parameter int DATA_WIDTH = 70,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           data_mac,
  input  logic [3:0]            valid_mac,
  input  logic                  eof_mac,
  output logic [DATA_WIDTH-1:0] data_router,
  output logic                  val,
  input  logic                  ack,
  output logic                  overflow,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // The top slot is kept in reserve so a terminator can always be written.
  localparam logic [CW-1:0] SPACE_LIMIT = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FRAME, DROP_TRUNC, DROP_ALL} state_t;

  state_t                state, state_next;
  logic                  beat, space, push, term_push, drop_set, pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  assign beat  = |valid_mac;
  assign space = count < SPACE_LIMIT;
  assign val   = count != '0;
  assign pop   = val & ack;

  // The reset value of data_router is 0, so the read port is masked when the FIFO is empty.
  assign data_router = val ? mem[rd_ptr] : '0;

  // State register for the frame-level accept/drop decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. Idle cycles never change state.
  always_comb begin
    state_next = state;
    if (beat) begin
      unique case (state)
        IDLE:       state_next = eof_mac ? IDLE : (space ? FRAME : DROP_ALL);
        FRAME:      state_next = eof_mac ? IDLE : (space ? FRAME : DROP_TRUNC);
        DROP_TRUNC: state_next = eof_mac ? IDLE : DROP_TRUNC;
        DROP_ALL:   state_next = eof_mac ? IDLE : DROP_ALL;
        default:    state_next = IDLE;
      endcase
    end
  end

  // Output logic. This block decides what, if anything, is written into the FIFO this cycle.
  // A terminator only ever lands in the reserved slot. In the drop states nothing
  // else is written, so that slot is still free when the terminator is needed.
  always_comb begin
    push      = 1'b0;
    term_push = 1'b0;
    drop_set  = 1'b0;
    push_data = '0;
    if (beat) begin
      unique case (state)
        IDLE: begin
          if (space) begin
            push      = 1'b1;
            push_data = {1'b1, eof_mac, data_mac, valid_mac};
          end else begin
            drop_set = 1'b1;
          end
        end
        FRAME: begin
          if (space) begin
            push      = 1'b1;
            push_data = {1'b0, eof_mac, data_mac, valid_mac};
          end else begin
            drop_set  = 1'b1;
            term_push = eof_mac;
          end
        end
        DROP_TRUNC: term_push = eof_mac;
        default: ;
      endcase
    end
    if (term_push) begin
      push      = 1'b1;
      push_data = {1'b0, 1'b1, 64'h0, 4'h0};
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Flit storage. The contents do not need a reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // overflow is high for exactly the cycle after the dropping edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= drop_set;
  end

`ifdef RX_MAC2ROUTER_STATS_EN
  logic frame_done;

  // A frame counts as accepted when its real eof flit is written. The terminator flit does not count.
  assign frame_done = push & ~term_push & eof_mac;

  // Saturating statistics counters. drop_cnt steps at the edge where overflow rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_done && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (drop_set && drop_cnt != 16'hFFFF)    drop_cnt  <= drop_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule
